instr_fetch: RTL and testbench

Instruction-fetch stage of the MIPS pipeline, sitting directly upstream of the instruction decoder. Holds the program counter, issues word requests to instruction memory over a request/ready handshake, and drives the IF/ID pipeline register whose `Instruction` output feeds the decoder. Handles downstream stalls with a one-entry skid buffer and branch/jump redirects with squashing of in-flight fetches.

---
 rtl/instr_fetch.sv | 225 ++++++++++++++++++++++
 tb/tb_instr_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction-fetch stage of the MIPS pipeline. Owns the program counter,
// issues word requests to instruction memory over a request/ready handshake
// and drives the IF/ID pipeline register that feeds the decoder.
// Downstream stalls are absorbed by a one-entry skid buffer. Branch and jump
// redirects squash any fetch still in flight.
//
// Parameters:
//   RESET_PC      fetch address after reset (word aligned)
//
// Ports:
//   Clk           rising-edge clock
//   Rst_n         asynchronous active-low reset
//   Stall         decode/hazard stall, holds IF/ID
//   Branch_Taken  redirect to Branch_Target (wins over a jump)
//   Branch_Target branch address, bits [1:0] ignored
//   Jump_Taken    redirect to {PC_Plus4[31:28], Jump_Index, 2'b00}
//   Jump_Index    26-bit J-type field
//   Imem_Req      fetch request valid (decoded from state)
//   Imem_Addr     word-aligned fetch address, stable while a request is open
//   Imem_Ready    memory returns Imem_Rdata this cycle
//   Imem_Rdata    fetched instruction word
//   Instruction   IF/ID instruction, 0 (NOP) when not valid
//   PC_Out        address of Instruction
//   PC_Plus4      PC_Out + 4
//   Valid         IF/ID holds a real instruction
// ----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Jump_Taken,
  input  logic [25:0] Jump_Index,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC_Out,
  output logic [31:0] PC_Plus4,
  output logic        Valid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,  // first cycle out of reset, no request yet
    S_REQ    = 2'd1,  // request open at r_fetch_pc
    S_HOLD   = 2'd2,  // skid buffer full, downstream stalled, no request
    S_SQUASH = 2'd3   // request open whose data must be thrown away
  } state_t;

  // Registered state
  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_skid_data;
  logic [31:0] r_skid_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // Next-state values
  state_t      w_state_nxt;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] w_redirect_pc_nxt;
  logic [31:0] w_skid_data_nxt;
  logic [31:0] w_skid_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pc_out_nxt;
  logic [31:0] w_pc_plus4_nxt;
  logic        w_valid_nxt;

  // Redirect decode
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_fetch_pc_inc;

  // IF/ID load request from the fetch FSM
  logic        w_ifid_load;
  logic [31:0] w_ifid_load_instr;
  logic [31:0] w_ifid_load_pc;

  assign w_redirect     = Branch_Taken | Jump_Taken;
  // The jump region comes from the PC of the instruction in IF/ID (the jump
  // itself), so the upper nibble is taken from PC_Plus4.
  assign w_target       = Branch_Taken ? (Branch_Target & ~32'h0000_0003)
                                       : {r_pc_plus4[31:28], Jump_Index, 2'b00};
  assign w_fetch_pc_inc = r_fetch_pc + 32'd4;

  // --------------------------------------------------------------------------
  // Next-state and datapath decode
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_redirect_pc_nxt = r_redirect_pc;
    w_skid_data_nxt   = r_skid_data;
    w_skid_pc_nxt     = r_skid_pc;
    w_ifid_load       = 1'b0;
    w_ifid_load_instr = Imem_Rdata;
    w_ifid_load_pc    = r_fetch_pc;

    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (w_redirect) w_fetch_pc_nxt = w_target;
      end

      S_REQ: begin
        if (Imem_Ready) begin
          if (w_redirect) begin
            // Returned word is on the wrong path: drop it and refetch.
            w_fetch_pc_nxt = w_target;
          end else if (!Stall) begin
            w_ifid_load    = 1'b1;
            w_fetch_pc_nxt = w_fetch_pc_inc;
          end else begin
            // Park the word so the stall costs no refetch.
            w_skid_data_nxt = Imem_Rdata;
            w_skid_pc_nxt   = r_fetch_pc;
            w_fetch_pc_nxt  = w_fetch_pc_inc;
            w_state_nxt     = S_HOLD;
          end
        end else if (w_redirect) begin
          // Request cannot be withdrawn; remember where to go once it lands.
          w_redirect_pc_nxt = w_target;
          w_state_nxt       = S_SQUASH;
        end
      end

      S_HOLD: begin
        if (w_redirect) begin
          // Leaving HOLD abandons the skid contents.
          w_fetch_pc_nxt = w_target;
          w_state_nxt    = S_REQ;
        end else if (!Stall) begin
          w_ifid_load       = 1'b1;
          w_ifid_load_instr = r_skid_data;
          w_ifid_load_pc    = r_skid_pc;
          w_state_nxt       = S_REQ;
        end
      end

      S_SQUASH: begin
        if (Imem_Ready) begin
          w_fetch_pc_nxt = w_redirect ? w_target : r_redirect_pc;
          w_state_nxt    = S_REQ;
        end else if (w_redirect) begin
          w_redirect_pc_nxt = w_target;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // IF/ID register: redirect flushes, a load fills, a consumed entry with
    // nothing new becomes a bubble, a stalled entry holds. The PC fields are
    // only rewritten by a load so PC_Plus4 keeps pointing at the last real
    // instruction (the jump source).
    w_instr_nxt    = r_instr;
    w_pc_out_nxt   = r_pc_out;
    w_pc_plus4_nxt = r_pc_plus4;
    w_valid_nxt    = r_valid;
    if (w_redirect) begin
      w_instr_nxt = 32'h0;
      w_valid_nxt = 1'b0;
    end else if (w_ifid_load) begin
      w_instr_nxt    = w_ifid_load_instr;
      w_pc_out_nxt   = w_ifid_load_pc;
      w_pc_plus4_nxt = w_ifid_load_pc + 32'd4;
      w_valid_nxt    = 1'b1;
    end else if (!Stall) begin
      w_instr_nxt = 32'h0;
      w_valid_nxt = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_redirect_pc <= 32'h0;
      r_skid_data   <= 32'h0;
      r_skid_pc     <= 32'h0;
      r_instr       <= 32'h0;
      r_pc_out      <= RESET_PC;
      r_pc_plus4    <= RESET_PC + 32'd4;
      r_valid       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_skid_data   <= w_skid_data_nxt;
      r_skid_pc     <= w_skid_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_pc_out      <= w_pc_out_nxt;
      r_pc_plus4    <= w_pc_plus4_nxt;
      r_valid       <= w_valid_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign Imem_Req    = (r_state == S_REQ) || (r_state == S_SQUASH);
  assign Imem_Addr   = r_fetch_pc;
  assign Instruction = r_instr;
  assign PC_Out      = r_pc_out;
  assign PC_Plus4    = r_pc_plus4;
  assign Valid       = r_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. Instruction memory returns ~address so the
// expected instruction for any PC is known without a lookup table. A vector
// table walks DUT "a" (RESET_PC = 0x100) through waits, stalls, branches and
// jumps; hand-written sequences cover asynchronous reset mid-request and PC
// wraparound on DUT "b" (RESET_PC = 0xFFFF_FFFC).
// ----------------------------------------------------------------------------
module tb_instr_fetch;

  logic Clk;
  logic Rst_n;

  // DUT a stimulus / observation
  logic        stall_a, br_a, jmp_a, ready_a;
  logic [31:0] br_tgt_a;
  logic [25:0] jidx_a;
  logic        req_a, valid_a;
  logic [31:0] addr_a, rdata_a, instr_a, pc_a, pc4_a;

  // DUT b: free-running zero-wait memory, no stalls or redirects
  logic        tie0;
  logic [31:0] tie0_32;
  logic [25:0] tie0_26;
  logic        ready_b;
  logic        req_b, valid_b;
  logic [31:0] addr_b, rdata_b, instr_b, pc_b, pc4_b;

  int checks;
  int errors;

  assign rdata_a = ~addr_a;
  assign rdata_b = ~addr_b;

  instr_fetch #(.RESET_PC(32'h0000_0100)) u_dut_a (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Stall        (stall_a),
    .Branch_Taken (br_a),
    .Branch_Target(br_tgt_a),
    .Jump_Taken   (jmp_a),
    .Jump_Index   (jidx_a),
    .Imem_Req     (req_a),
    .Imem_Addr    (addr_a),
    .Imem_Ready   (ready_a),
    .Imem_Rdata   (rdata_a),
    .Instruction  (instr_a),
    .PC_Out       (pc_a),
    .PC_Plus4     (pc4_a),
    .Valid        (valid_a)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Stall        (tie0),
    .Branch_Taken (tie0),
    .Branch_Target(tie0_32),
    .Jump_Taken   (tie0),
    .Jump_Index   (tie0_26),
    .Imem_Req     (req_b),
    .Imem_Addr    (addr_b),
    .Imem_Ready   (ready_b),
    .Imem_Rdata   (rdata_b),
    .Instruction  (instr_b),
    .PC_Out       (pc_b),
    .PC_Plus4     (pc4_b),
    .Valid        (valid_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // One row per clock cycle: inputs driven for that cycle and the outputs
  // expected to be visible during it (i.e. from the previous edge).
  typedef struct packed {
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [25:0] jidx;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic stall, input logic br,
                              input logic [31:0] br_tgt, input logic jmp,
                              input logic [25:0] jidx, input logic ready,
                              input logic exp_req, input logic [31:0] exp_addr,
                              input logic exp_valid, input logic [31:0] exp_pc);
    vec_t v;
    v.stall     = stall;
    v.br        = br;
    v.br_tgt    = br_tgt;
    v.jmp       = jmp;
    v.jidx      = jidx;
    v.ready     = ready;
    v.exp_req   = exp_req;
    v.exp_addr  = exp_addr;
    v.exp_valid = exp_valid;
    v.exp_pc    = exp_pc;
    return v;
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    tie0     = 1'b0;
    tie0_32  = 32'h0;
    tie0_26  = 26'h0;
    ready_b  = 1'b1;
    Rst_n    = 1'b0;
    stall_a  = 1'b0;
    br_a     = 1'b0;
    br_tgt_a = 32'h0;
    jmp_a    = 1'b0;
    jidx_a   = 26'h0;
    ready_a  = 1'b0;

    //                 stall br  br_tgt        jmp jidx      rdy  req addr          vld pc
    vecs[0]  = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b0,32'h0000_0100,1'b0,32'h0000_0100); // reset state
    vecs[1]  = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b1,32'h0000_0100,1'b0,32'h0000_0100); // first request
    vecs[2]  = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b0,1'b1,32'h0000_0104,1'b1,32'h0000_0100); // 0x100 valid, wait 1
    vecs[3]  = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b0,1'b1,32'h0000_0104,1'b0,32'h0000_0100); // wait 2, bubble
    vecs[4]  = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b0,1'b1,32'h0000_0104,1'b0,32'h0000_0100); // wait 3
    vecs[5]  = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b1,32'h0000_0104,1'b0,32'h0000_0100); // 0x104 ready
    vecs[6]  = mk(1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b1,32'h0000_0108,1'b1,32'h0000_0104); // stall as 0x108 returns
    vecs[7]  = mk(1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b0,32'h0000_010C,1'b1,32'h0000_0104); // HOLD, no req
    vecs[8]  = mk(1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b0,32'h0000_010C,1'b1,32'h0000_0104); // HOLD
    vecs[9]  = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b0,32'h0000_010C,1'b1,32'h0000_0104); // stall drops
    vecs[10] = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b1,32'h0000_010C,1'b1,32'h0000_0108); // skid drained
    vecs[11] = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b0,1'b1,32'h0000_0110,1'b1,32'h0000_010C); // 0x110 pending
    vecs[12] = mk(1'b0,1'b1,32'h0000_0200,1'b0,26'h0,   1'b0,1'b1,32'h0000_0110,1'b0,32'h0000_010C); // branch while pending
    vecs[13] = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b1,32'h0000_0110,1'b0,32'h0000_010C); // squashed data lands
    vecs[14] = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b1,32'h0000_0200,1'b0,32'h0000_010C); // fetch target
    vecs[15] = mk(1'b0,1'b1,32'h3000_0000,1'b0,26'h0,   1'b1,1'b1,32'h0000_0204,1'b1,32'h0000_0200); // zero-wait branch
    vecs[16] = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b1,32'h3000_0000,1'b0,32'h0000_0200); // one bubble
    vecs[17] = mk(1'b0,1'b0,32'h0,        1'b1,26'h40,  1'b1,1'b1,32'h3000_0004,1'b1,32'h3000_0000); // jump
    vecs[18] = mk(1'b0,1'b1,32'h0000_0400,1'b1,26'h40,  1'b1,1'b1,32'h3000_0100,1'b0,32'h3000_0000); // branch beats jump
    vecs[19] = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b1,32'h0000_0400,1'b0,32'h3000_0000);
    vecs[20] = mk(1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b1,32'h0000_0404,1'b1,32'h0000_0400); // stall into HOLD
    vecs[21] = mk(1'b1,1'b1,32'h0000_0503,1'b0,26'h0,   1'b1,1'b0,32'h0000_0408,1'b1,32'h0000_0400); // redirect beats stall
    vecs[22] = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b1,1'b1,32'h0000_0500,1'b0,32'h0000_0400); // low bits dropped
    vecs[23] = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b0,1'b1,32'h0000_0504,1'b1,32'h0000_0500);
    vecs[24] = mk(1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b0,1'b1,32'h0000_0504,1'b0,32'h0000_0500); // request left open

    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      check($sformatf("v%0d req", i),   {31'h0, req_a},   {31'h0, vecs[i].exp_req});
      check($sformatf("v%0d addr", i),  addr_a,           vecs[i].exp_addr);
      check($sformatf("v%0d valid", i), {31'h0, valid_a}, {31'h0, vecs[i].exp_valid});
      check($sformatf("v%0d pc", i),    pc_a,             vecs[i].exp_pc);
      check($sformatf("v%0d pc4", i),   pc4_a,            vecs[i].exp_pc + 32'd4);
      check($sformatf("v%0d instr", i), instr_a,
            vecs[i].exp_valid ? ~vecs[i].exp_pc : 32'h0);
      stall_a  = vecs[i].stall;
      br_a     = vecs[i].br;
      br_tgt_a = vecs[i].br_tgt;
      jmp_a    = vecs[i].jmp;
      jidx_a   = vecs[i].jidx;
      ready_a  = vecs[i].ready;
      @(negedge Clk);
    end

    // Asynchronous reset while DUT a has a request open at 0x504.
    check("pre-reset req", {31'h0, req_a}, 32'h1);
    stall_a = 1'b0;
    br_a    = 1'b0;
    jmp_a   = 1'b0;
    ready_a = 1'b0;
    Rst_n   = 1'b0;
    #1;
    check("rst req",   {31'h0, req_a},   32'h0);
    check("rst valid", {31'h0, valid_a}, 32'h0);
    check("rst instr", instr_a,          32'h0);
    check("rst addr",  addr_a,           32'h0000_0100);
    check("rst pc",    pc_a,             32'h0000_0100);
    check("rst pc4",   pc4_a,            32'h0000_0104);
    check("b rst addr", addr_b,          32'hFFFF_FFFC);
    check("b rst pc4",  pc4_b,           32'h0000_0000);
    check("b rst req",  {31'h0, req_b},  32'h0);

    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    // Edge 1 after release: both request their reset PC.
    check("b e1 req",  {31'h0, req_b},   32'h1);
    check("b e1 addr", addr_b,           32'hFFFF_FFFC);
    check("a e1 req",  {31'h0, req_a},   32'h1);
    check("a e1 addr", addr_a,           32'h0000_0100);
    check("a e1 valid", {31'h0, valid_a}, 32'h0);
    @(negedge Clk);
    // Edge 2: b wraps to 0; a is still waiting, nothing stale appears.
    check("b wrap addr",  addr_b,           32'h0000_0000);
    check("b wrap valid", {31'h0, valid_b}, 32'h1);
    check("b wrap pc",    pc_b,             32'hFFFF_FFFC);
    check("b wrap pc4",   pc4_b,            32'h0000_0000);
    check("b wrap instr", instr_b,          32'h0000_0003);
    check("a wait valid", {31'h0, valid_a}, 32'h0);
    check("a wait addr",  addr_a,           32'h0000_0100);
    @(negedge Clk);
    check("b next pc",    pc_b,             32'h0000_0000);
    check("b next addr",  addr_b,           32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
